// File: rtl/tdm_demux8.sv
// rtl/tdm_demux8.sv - TDM serial-to-parallel demultiplexer, 8 channels, with framing check
//
// Rebuilds one 8-bit channel word from eight serial slots. Slot 0 is marked by
// frame_start. Framing violations raise frame_err and cause a resynchronisation.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   din          serial bit for the current slot
//   din_valid    qualifies din and frame_start; the slot advances only on valid beats
//   frame_start  marks the slot-0 beat of a frame
//   ch_out       last complete frame, bit i = slot i
//   ch_valid     one-cycle pulse when ch_out takes a new frame
//   slot         index of the next slot to be captured
//   frame_err    one-cycle pulse on a framing violation
//   busy         high while locked to the frame (RUN)

module tdm_demux8 #(
    parameter logic [7:0] CH_RST_VAL  = 8'h00,
    parameter bit         HOLD_ON_ERR = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic       din_valid,
    input  logic       frame_start,
    output logic [7:0] ch_out,
    output logic       ch_valid,
    output logic [2:0] slot,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state;

    // Slots 0..6 are staged here; slot 7 goes straight into ch_out together
    // with this vector, so the completed word appears on the slot-7 edge.
    logic [6:0] shadow;

    // Value ch_out takes when a frame is abandoned.
    logic [7:0] err_val;

    // Single-bit write into shadow at the current slot position.
    logic [6:0] slot_mask;
    logic [6:0] slot_bit;

    assign err_val   = HOLD_ON_ERR ? ch_out : CH_RST_VAL;
    assign slot_mask = 7'd1 << slot;
    assign slot_bit  = 7'(din) << slot;
    assign busy      = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            slot      <= 3'd0;
            shadow    <= 7'd0;
            ch_out    <= CH_RST_VAL;
            ch_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            ch_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (din_valid) begin
                case (state)
                    IDLE: begin
                        // Unstrobed beats are dropped silently while hunting.
                        if (frame_start) begin
                            shadow <= {shadow[6:1], din};
                            slot   <= 3'd1;
                            state  <= RUN;
                        end
                    end
                    RUN: begin
                        if (frame_start) begin
                            // A strobe anywhere but slot 0 aborts the partial
                            // frame; the strobed beat itself starts a new one.
                            if (slot != 3'd0) begin
                                frame_err <= 1'b1;
                                ch_out    <= err_val;
                            end
                            shadow <= {shadow[6:1], din};
                            slot   <= 3'd1;
                        end else if (slot == 3'd0) begin
                            // Expected a strobe and got none: lock is lost.
                            frame_err <= 1'b1;
                            ch_out    <= err_val;
                            state     <= IDLE;
                            slot      <= 3'd0;
                        end else if (slot == 3'd7) begin
                            ch_out   <= {din, shadow};
                            ch_valid <= 1'b1;
                            slot     <= 3'd0;
                        end else begin
                            shadow <= (shadow & ~slot_mask) | slot_bit;
                            slot   <= slot + 3'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        slot  <= 3'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux8.sv
// tb/tb_tdm_demux8.sv - scoreboard bench for tdm_demux8 (hold and clear-on-error variants)

module tb_tdm_demux8;

    localparam logic [7:0] RST_B = 8'h5A;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din;
    logic       din_valid;
    logic       frame_start;

    logic [7:0] ch_out_a,    ch_out_b;
    logic       ch_valid_a,  ch_valid_b;
    logic [2:0] slot_a,      slot_b;
    logic       frame_err_a, frame_err_b;
    logic       busy_a,      busy_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_valid_cyc = -1;

    typedef struct {
        bit         is_err;
        logic [7:0] word;
    } ev_t;

    ev_t        exp_q[$];
    bit         m_sync;
    bit         m_bits[$];
    logic [7:0] m_ch_a;
    logic [7:0] m_ch_b;

    tdm_demux8 u_hold (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_start(frame_start),
        .ch_out     (ch_out_a),
        .ch_valid   (ch_valid_a),
        .slot       (slot_a),
        .frame_err  (frame_err_a),
        .busy       (busy_a)
    );

    tdm_demux8 #(.CH_RST_VAL(RST_B), .HOLD_ON_ERR(1'b0)) u_clr (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_start(frame_start),
        .ch_out     (ch_out_b),
        .ch_valid   (ch_valid_b),
        .slot       (slot_b),
        .frame_err  (frame_err_b),
        .busy       (busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sync = 1'b0;
        m_bits.delete();
        m_ch_a = 8'h00;
        m_ch_b = RST_B;
        exp_q.delete();
    endtask

    // Frame-level reference: a frame is a run of 8 valid beats whose first one
    // carries the strobe; anything else while locked is an error.
    task automatic model_step(input bit fs, input bit d);
        ev_t        ev;
        logic [7:0] w;
        if (fs) begin
            if (m_sync && m_bits.size() != 0) begin
                ev.is_err = 1'b1; ev.word = 8'h00; exp_q.push_back(ev);
                m_ch_b = RST_B;
            end
            m_bits.delete();
            m_bits.push_back(d);
            m_sync = 1'b1;
        end else if (m_sync) begin
            if (m_bits.size() == 0) begin
                ev.is_err = 1'b1; ev.word = 8'h00; exp_q.push_back(ev);
                m_ch_b = RST_B;
                m_sync = 1'b0;
            end else begin
                m_bits.push_back(d);
                if (m_bits.size() == 8) begin
                    for (int i = 0; i < 8; i++) w[i] = m_bits[i];
                    ev.is_err = 1'b0; ev.word = w; exp_q.push_back(ev);
                    m_ch_a = w;
                    m_ch_b = w;
                    m_bits.delete();
                end
            end
        end
    endtask

    task automatic beat(input bit v, input bit fs, input bit d);
        din_valid   = v;
        frame_start = fs;
        din         = d;
        @(posedge clk);
        if (v) model_step(fs, d);
        #1;
    endtask

    task automatic frame(input logic [7:0] w);
        for (int i = 0; i < 8; i++) beat(1'b1, i == 0, w[i]);
    endtask

    task automatic do_reset();
        din_valid   = 1'b0;
        frame_start = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_ch_out_a", ch_out_a, 8'h00);
        check("rst_ch_out_b", ch_out_b, RST_B);
        check("rst_slot", slot_a, 3'd0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_pulses", {ch_valid_a, frame_err_a, ch_valid_b, frame_err_b}, 4'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: per-cycle state checks plus scoreboard matching of pulses.
    initial begin
        ev_t ev;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                check("slot_a", slot_a, m_bits.size());
                check("slot_b", slot_b, m_bits.size());
                check("busy_a", busy_a, m_sync);
                check("busy_b", busy_b, m_sync);
                check("ch_out_a", ch_out_a, m_ch_a);
                check("ch_out_b", ch_out_b, m_ch_b);
                check("pulse_excl", ch_valid_a & frame_err_a, 1'b0);
                check("pulse_b_eq_a", {ch_valid_b, frame_err_b}, {ch_valid_a, frame_err_a});
                if (ch_valid_a) last_valid_cyc = cyc;
                if (ch_valid_a || frame_err_a) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_pulse", {ch_valid_a, frame_err_a}, 2'b00);
                    end else begin
                        ev = exp_q.pop_front();
                        check("pulse_kind", {ch_valid_a, frame_err_a}, ev.is_err ? 2'b01 : 2'b10);
                        if (!ev.is_err) check("frame_word", ch_out_a, ev.word);
                    end
                end else if (exp_q.size() != 0) begin
                    ev = exp_q.pop_front();
                    check("missing_pulse", {ch_valid_a, frame_err_a}, ev.is_err ? 2'b01 : 2'b10);
                end
            end
        end
    end

    initial begin
        int          t0;
        bit          v, fs;
        logic [7:0]  gw;
        rst_n       = 1'b0;
        din         = 1'b0;
        din_valid   = 1'b0;
        frame_start = 1'b0;
        model_reset();
        do_reset();

        // Single frame, slots 1,0,0,0,1,1,0,1 -> B1.
        t0 = cyc;
        frame(8'hB1);
        beat(1'b0, 1'b0, 1'b0);
        check("single_latency", last_valid_cyc - t0, 8);
        check("single_word", ch_out_a, 8'hB1);

        // Same frame with gaps: 3 idle after slot 2, 1 idle after slot 5.
        gw = 8'hB1;
        t0 = cyc;
        for (int i = 0; i < 8; i++) begin
            beat(1'b1, i == 0, gw[i]);
            if (i == 2) for (int k = 0; k < 3; k++) beat(1'b0, 1'b1, 1'b1);
            if (i == 5) beat(1'b0, 1'b0, 1'b0);
        end
        beat(1'b0, 1'b0, 1'b0);
        check("gapped_latency", last_valid_cyc - t0, 12);

        // Back-to-back frames.
        frame(8'hB1);
        frame(8'hA6);
        beat(1'b0, 1'b0, 1'b0);
        check("b2b_word", ch_out_a, 8'hA6);

        // Early strobe at slot 4, then clean all-ones frame.
        for (int i = 0; i < 4; i++) beat(1'b1, i == 0, 1'b0);
        frame(8'hFF);

        // Missing strobe after a good frame, then ignored beats.
        beat(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) beat(1'b1, 1'b0, 1'b1);
        frame(8'h3C);

        // Reset mid-frame at slot 5.
        for (int i = 0; i < 5; i++) beat(1'b1, i == 0, 1'b1);
        do_reset();
        frame(8'h96);

        // Random traffic with occasional framing faults and resets.
        for (int n = 0; n < 1500; n++) begin
            v = ($urandom_range(0, 3) != 0);
            if (!m_sync || m_bits.size() == 0)
                fs = ($urandom_range(0, 9) != 0);
            else
                fs = ($urandom_range(0, 24) == 0);
            beat(v, fs, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 299) == 0) do_reset();
        end

        for (int i = 0; i < 3; i++) beat(1'b0, 1'b0, 1'b0);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
